// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame status constants and helpers
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_mode_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic PCKT_OK     = 1'b0;
  localparam logic PCKT_NOT_OK = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick, one r_clk pulse every DIV clocks
module uart_baud_tick #(
  parameter int CLK_HZ     = 32_000_000,
  parameter int BAUD       = 1_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic r_clk,
  input  logic r_rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_err_div
    $error("uart_baud_tick: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with valid/ready holding register
// Optional 2-of-3 majority bit decision: UART_RX_MAJORITY_EN
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int           CLK_HZ      = 32_000_000,
  parameter int           BAUD        = 1_000_000,
  parameter int           OVERSAMPLE  = 16,
  parameter int           DATA_BITS   = 8,
  parameter parity_mode_e PARITY_MODE = PAR_EVEN,
  parameter int           STOP_BITS   = 1
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_err_os
    $error("uart_rx_param: OVERSAMPLE must be even and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_sb
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic                 w_tick;
  rx_state_e            r_state, w_state_nxt;
  logic                 r_sync1, r_sync2;
  logic [SCW-1:0]       r_scnt;
  logic [3:0]           r_bcnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_perr, r_ferr, r_valid, r_perr_q, r_ferr_q, r_ovr, r_armed;
  logic                 w_bit, w_decide, w_bit_end, w_commit, w_par_bad, w_ferr_fin;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .r_clk(r_clk),
    .r_rst(r_rst),
    .tick (w_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCW-1:0] SC_DECIDE = SCW'(OVERSAMPLE / 2 + 1);
  logic r_s0, r_s1;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (r_scnt == SCW'(OVERSAMPLE / 2 - 1)) r_s0 <= r_sync2;
      if (r_scnt == SCW'(OVERSAMPLE / 2)) r_s1 <= r_sync2;
    end
  end

  assign w_bit = maj3(r_s0, r_s1, r_sync2);
`else
  localparam logic [SCW-1:0] SC_DECIDE = SCW'(OVERSAMPLE / 2);
  assign w_bit = r_sync2;
`endif

  assign w_decide   = w_tick && (r_scnt == SC_DECIDE);
  assign w_bit_end  = w_tick && (r_scnt == SC_LAST);
  assign w_par_bad  = (^r_shift) ^ w_bit ^ (PARITY_MODE == PAR_ODD);
  assign w_ferr_fin = r_ferr | ~w_bit;

  always_ff @(posedge r_clk) begin
    if (r_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Commit happens at the last stop decision so the next start edge is never missed
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      IDLE:   if (w_tick && r_armed && !r_sync2) w_state_nxt = START;
      START: begin
        if (w_decide && w_bit)  w_state_nxt = IDLE;
        else if (w_bit_end)     w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end && r_bcnt == 4'(DATA_BITS - 1))
          w_state_nxt = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
      end
      PARITY: if (w_bit_end) w_state_nxt = STOP;
      STOP: begin
        if (w_decide && r_bcnt == 4'(STOP_BITS - 1)) begin
          w_state_nxt = IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_scnt   <= '0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_perr   <= PCKT_OK;
      r_ferr   <= PCKT_OK;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= PCKT_OK;
      r_ferr_q <= PCKT_OK;
      r_ovr    <= 1'b0;
      r_armed  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_ovr   <= 1'b0;

      if (r_state == IDLE || w_state_nxt == IDLE) r_scnt <= '0;
      else if (w_bit_end)                         r_scnt <= '0;
      else if (w_tick)                            r_scnt <= r_scnt + 1'b1;

      if (w_state_nxt != r_state) r_bcnt <= '0;
      else if (w_bit_end)         r_bcnt <= r_bcnt + 1'b1;

      if (r_state == IDLE) begin
        r_perr <= PCKT_OK;
        r_ferr <= PCKT_OK;
      end
      if (r_state == DATA && w_decide)            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (r_state == PARITY && w_decide)          r_perr  <= w_par_bad;
      if (r_state == STOP && w_decide && !w_bit)  r_ferr  <= PCKT_NOT_OK;

      if (w_commit) begin
        if (!r_valid || rx_ready) begin
          r_data   <= r_shift;
          r_perr_q <= r_perr;
          r_ferr_q <= w_ferr_fin;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      // A break (all-zero data with bad stop) disarms until the line goes idle again
      if (w_commit && w_ferr_fin && r_shift == '0) r_armed <= 1'b0;
      else if (w_tick && r_sync2)                  r_armed <= 1'b1;
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr_q;
  assign frame_err   = r_ferr_q;
  assign overrun_err = r_ovr;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param (8E1, 8N1, 7O2)
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, rx_line, ready;
  logic [2:0] vld, perr, ferr, ovr, bsy;
  logic [7:0] d0, d1;
  logic [6:0] d2;

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
    .r_clk(clk), .r_rst(rst[0]), .rx_in(rx_line[0]), .rx_data(d0), .rx_valid(vld[0]),
    .rx_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]),
    .busy(bsy[0]));
  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_8n1 (
    .r_clk(clk), .r_rst(rst[1]), .rx_in(rx_line[1]), .rx_data(d1), .rx_valid(vld[1]),
    .rx_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]),
    .busy(bsy[1]));
  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(PAR_ODD), .STOP_BITS(2)) u_7o2 (
    .r_clk(clk), .r_rst(rst[2]), .rx_in(rx_line[2]), .rx_data(d2), .rx_valid(vld[2]),
    .rx_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(ovr[2]),
    .busy(bsy[2]));

  int n_total = 0;
  int n_pass  = 0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  int ovr_cnt = 0;

  // frame record: {dut[1:0], frame_err, parity_err, data[8:0]}
  always @(negedge clk) begin
    if (vld[0] && ready[0]) got_q.push_back({2'd0, ferr[0], perr[0], 1'b0, d0});
    if (vld[1] && ready[1]) got_q.push_back({2'd1, ferr[1], perr[1], 1'b0, d1});
    if (vld[2] && ready[2]) got_q.push_back({2'd2, ferr[2], perr[2], 2'b0, d2});
    if (ovr[0]) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int nbits_of(input int sel);
    return (sel == 2) ? 7 : 8;
  endfunction
  function automatic int pmode_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 0 : 2;
  endfunction
  function automatic int nstop_of(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int sel, input int n);
    rx_line[sel] = 1'b1;
    repeat (n * BIT_CLKS) tick_clk();
  endtask

  // Builds the line waveform from the frame rules and records the expected delivery
  task automatic send_frame(input int sel, input logic [8:0] data, input logic par_flip,
                            input logic [1:0] stops, input int glitch_bit, input int max_clks);
    logic bits[$];
    int nb, pm, ns, ones, n;
    logic pbit, pe, fe;
    logic [8:0] dm;
    nb = nbits_of(sel);
    pm = pmode_of(sel);
    ns = nstop_of(sel);
    ones = 0;
    dm = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      dm[i] = data[i];
      ones += int'(data[i]);
    end
    pbit = 1'b0;
    if (pm != 0) begin
      pbit = ((ones % 2 == 1) ^ (pm == 2)) ^ par_flip;
      bits.push_back(pbit);
    end
    fe = 1'b0;
    for (int s = 0; s < ns; s++) begin
      bits.push_back(stops[s]);
      if (!stops[s]) fe = 1'b1;
    end
    pe = (pm != 0) && (((ones + int'(pbit)) % 2) != ((pm == 2) ? 1 : 0));
    exp_q.push_back({2'(sel), fe, pe, dm});
    n = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (max_clks > 0 && n >= max_clks) return;
        rx_line[sel] = bits[b] ^ ((b == glitch_bit) && (c >= 18) && (c < 20));
        tick_clk();
        n++;
      end
    end
  endtask

  task automatic check_frames(input string tag);
    int n;
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".frame"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    logic [8:0] d;
    rx_line = 3'b111;
    ready   = 3'b111;
    rst     = 3'b111;
    repeat (2) tick_clk();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset.valid", vld[i], 1'b0);
      chk("reset.busy", bsy[i], 1'b0);
      chk("reset.flags", {perr[i], ferr[i], ovr[i]}, 3'b000);
    end
    chk("reset.data", {d0, d1, d2}, 23'd0);
    tick_clk();
    rst = 3'b000;
    idle_bits(0, 2);

    send_frame(0, 9'hA5, 1'b0, 2'b11, -1, 0);
    idle_bits(0, 1);
    check_frames("8e1_a5_good");
    send_frame(0, 9'hA5, 1'b1, 2'b11, -1, 0);
    idle_bits(0, 1);
    check_frames("8e1_a5_badpar");

    for (int k = 0; k < 8; k++) begin
      d = 9'($urandom_range(0, 255));
      send_frame(0, d, ($urandom_range(0, 3) == 0), 2'b11, -1, 0);
      idle_bits(0, 1);
      d = 9'($urandom_range(0, 127));
      send_frame(2, d, ($urandom_range(0, 3) == 0), 2'b11, -1, 0);
      idle_bits(2, 1);
    end
    check_frames("random");

    ready[0] = 1'b0;
    base = ovr_cnt;
    send_frame(0, 9'h11, 1'b0, 2'b11, -1, 0);
    idle_bits(0, 1);
    send_frame(0, 9'h22, 1'b0, 2'b11, -1, 0);
    idle_bits(0, 1);
    void'(exp_q.pop_back());
    chk("ovr.valid_held", vld[0], 1'b1);
    chk("ovr.data_held", d0, 8'h11);
    chk("ovr.pulses", ovr_cnt - base, 1);
    ready[0] = 1'b1;
    tick_clk();
    chk("ovr.valid_drop", vld[0], 1'b0);
    check_frames("ovr_accept");

    send_frame(1, 9'h000, 1'b0, 2'b00, -1, 0);
    rx_line[1] = 1'b0;
    repeat (20 * BIT_CLKS) tick_clk();
    check_frames("break_once");
    idle_bits(1, 2);
    send_frame(1, 9'h05A, 1'b0, 2'b11, -1, 0);
    idle_bits(1, 1);
    check_frames("break_recover");

    rx_line[1] = 1'b0;
    repeat (8) tick_clk();
    chk("glitch.busy_seen", bsy[1], 1'b1);
    idle_bits(1, 1);
    chk("glitch.busy_clear", bsy[1], 1'b0);
    check_frames("glitch_none");

    send_frame(2, 9'h03C, 1'b0, 2'b11, -1, BIT_CLKS * 4 + BIT_CLKS / 2);
    void'(exp_q.pop_back());
    chk("rst.busy_before", bsy[2], 1'b1);
    rst[2] = 1'b1;
    rx_line[2] = 1'b1;
    tick_clk();
    rst[2] = 1'b0;
    @(negedge clk);
    chk("rst.outputs", {vld[2], bsy[2], perr[2], ferr[2], ovr[2], d2}, 12'd0);
    idle_bits(2, 2);
    send_frame(2, 9'h02B, 1'b0, 2'b11, -1, 0);
    idle_bits(2, 1);
    check_frames("rst_next_frame");

`ifdef UART_RX_MAJORITY_EN
    send_frame(2, 9'h02B, 1'b0, 2'b11, 4, 0);
    idle_bits(2, 1);
    send_frame(0, 9'h0C3, 1'b0, 2'b11, 3, 0);
    idle_bits(0, 1);
    check_frames("majority_glitch");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
